// File: rtl/riscv_pipe_pkg.sv
// ID/EX bus layout and hazard FSM encoding shared by decode, EX and hazard control.
// Latency: none (types and constants only); backpressure: n/a.
package riscv_pipe_pkg;

    localparam int ID_EX_W = 158;

    localparam int MM_LSB    = 0;    localparam int MM_MSB    = 31;
    localparam int RD1_LSB   = 32;   localparam int RD1_MSB   = 63;
    localparam int RD2_LSB   = 64;   localparam int RD2_MSB   = 95;
    localparam int RD_LSB    = 96;   localparam int RD_MSB    = 100;
    localparam int ALUOP_LSB = 101;  localparam int ALUOP_MSB = 103;
    localparam int REGWRITE_BIT = 104;
    localparam int MEMTOREG_BIT = 105;
    localparam int MEMWRITE_BIT = 106;
    localparam int MEMREAD_BIT  = 107;
    localparam int JAL_BIT      = 108;
    localparam int JALR_BIT     = 109;
    localparam int BRANCH_BIT   = 110;
    localparam int ALUSRC_BIT   = 111;
    localparam int FUNC3_LSB = 112;  localparam int FUNC3_MSB = 114;
    localparam int FUNC7_BIT    = 115;
    localparam int PC_LSB    = 116;  localparam int PC_MSB    = 147;
    localparam int RS1_LSB   = 148;  localparam int RS1_MSB   = 152;
    localparam int RS2_LSB   = 153;  localparam int RS2_MSB   = 157;

    typedef struct packed {
        logic [31:0] mm_unit;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        jal;
        logic        jalr;
        logic        branch;
        logic        alu_src;
        logic [2:0]  func3;
        logic        func7;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } id_ex_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/id_ex_unpack.sv
// Slices the packed ID/EX bus into named fields for EX-stage consumers.
// Latency: purely combinational; backpressure: none.
module id_ex_unpack
    import riscv_pipe_pkg::*;
(
    input  logic [ID_EX_W-1:0] bus_dat,
    output id_ex_t             fields
);

    always_comb begin
        fields            = '0;
        fields.mm_unit    = bus_dat[MM_MSB:MM_LSB];
        fields.rd1        = bus_dat[RD1_MSB:RD1_LSB];
        fields.rd2        = bus_dat[RD2_MSB:RD2_LSB];
        fields.rd         = bus_dat[RD_MSB:RD_LSB];
        fields.alu_op     = bus_dat[ALUOP_MSB:ALUOP_LSB];
        fields.reg_write  = bus_dat[REGWRITE_BIT];
        fields.mem_to_reg = bus_dat[MEMTOREG_BIT];
        fields.mem_write  = bus_dat[MEMWRITE_BIT];
        fields.mem_read   = bus_dat[MEMREAD_BIT];
        fields.jal        = bus_dat[JAL_BIT];
        fields.jalr       = bus_dat[JALR_BIT];
        fields.branch     = bus_dat[BRANCH_BIT];
        fields.alu_src    = bus_dat[ALUSRC_BIT];
        fields.func3      = bus_dat[FUNC3_MSB:FUNC3_LSB];
        fields.func7      = bus_dat[FUNC7_BIT];
        fields.pc         = bus_dat[PC_MSB:PC_LSB];
        fields.rs1        = bus_dat[RS1_MSB:RS1_LSB];
        fields.rs2        = bus_dat[RS2_MSB:RS2_LSB];
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall and EX-redirect flush control for the PC, IF/ID and ID/EX registers.
// Latency: outputs combinational from state and inputs; a load-use hazard costs 1 cycle, a redirect FLUSH_CYCLES.
module id_ex_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ID_EX_W-1:0]     DataIn_ID_EX,
    input  logic [4:0]             if_id_rs1,
    input  logic [4:0]             if_id_rs2,
    input  logic                   if_id_uses_rs2,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_enable,
    output logic                   id_ex_bubble,
    output logic                   redirect,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    id_ex_t    ex;
    hz_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic redir, lu, stall_inc;

    id_ex_unpack u_unpack (
        .bus_dat (DataIn_ID_EX),
        .fields  (ex)
    );

    // Fields carried on the bus for the EX datapath but irrelevant to hazard detection.
    logic unused_fields;
    assign unused_fields = ^{ex.mm_unit, ex.rd1, ex.rd2, ex.alu_op, ex.reg_write,
                             ex.mem_to_reg, ex.mem_write, ex.alu_src, ex.func3,
                             ex.func7, ex.pc, ex.rs1, ex.rs2};

    assign redir = ex.jal | ex.jalr | (ex.branch & branch_taken);
    assign lu    = ex.mem_read && (ex.rd != 5'd0) &&
                   ((ex.rd == if_id_rs1) || (if_id_uses_rs2 && (ex.rd == if_id_rs2)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_enable = 1'b1;
        id_ex_bubble = 1'b0;
        redirect     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redir) begin
                    redirect     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = FLUSH_LOAD;
                    state_d      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (lu) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_LOAD_STALL;
                end
            end
            // The stalled load has left EX; the bubble behind it needs no action.
            ST_LOAD_STALL: state_d = ST_RUN;
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                cnt_d        = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (cnt_q <= 3'd1)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_inc   = ~pc_write | id_ex_bubble;
    assign stall_count = stall_count_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 3'd0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_inc && (stall_count_q != '1))
                stall_count_q <= stall_count_q + 1'b1;
        end
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Hazard and stall controller at the consuming end of the ID/EX pipeline register. It unpacks the 158-bit `DataOut_ID_EX` bus and compares the EX-stage instruction against the register sources currently in IF/ID. From that it drives the write enables of the PC, IF/ID and ID/EX registers, plus the bubble and flush controls. It resolves load-use hazards with a one-cycle stall and resolves taken branch/JAL/JALR redirects with a parameterised multi-cycle flush.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: bubble cycles inserted per EX redirect; legal range 1–7.
- `STALL_CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  clock; all state updates on the negedge, matching the pipeline registers.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `DataIn_ID_EX`  in  158  packed ID/EX bus. Field bit ranges:
  - mm_Unit [31:0]; Rd1 [63:32]; Rd2 [95:64]; RD [100:96]; ALUOp [103:101]
  - RegWrite 104; MemToReg 105; MemWrite 106; MemRead 107
  - Jal 108; Jalr 109; Branch 110; AluSrc 111
  - func3 [114:112]; func7 115; pc [147:116]; Rs1 [152:148]; Rs2 [157:153]
- `if_id_rs1`  in  5  rs1 of the instruction in decode.
- `if_id_rs2`  in  5  rs2 of the instruction in decode.
- `if_id_uses_rs2`  in  1  decode instruction reads rs2 (R/S/B type).
- `branch_taken`  in  1  EX branch comparison result; qualified by Branch.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_ex_enable`  out  1  ID/EX register enable.
- `id_ex_bubble`  out  1  zero all control fields entering ID/EX.
- `redirect`  out  1  select the EX target as next PC.
- `stall_count`  out  `STALL_CNT_W`  saturating count of stall and bubble cycles.

## Operation
- FSM states: RUN, LOAD_STALL, FLUSH. Reset state is RUN.
- Decoded conditions:
  - `redir` = Jal | Jalr | (Branch & branch_taken).
  - `lu` = MemRead & (RD≠0) & ((RD==if_id_rs1) | (if_id_uses_rs2 & RD==if_id_rs2)).
- RUN:
  - If `redir`: redirect=1, pc_write=1, if_id_flush=1, id_ex_bubble=1, id_ex_enable=1. Counter loads FLUSH_CYCLES−1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
  - Else if `lu`: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_enable=1. Next state LOAD_STALL.
  - Else: all write enables 1; bubble, flush and redirect 0.
- LOAD_STALL: normal outputs for one cycle (the load has moved to MEM and the bubble is in EX). Next state RUN.
- FLUSH: pc_write=1, if_id_flush=1, id_ex_bubble=1, redirect=0. Counter decrements; when it reaches 0, next state is RUN.
- `redir` and `lu` are ignored outside RUN. EX holds a bubble there, so all its control bits are zero.
- Priority: `redir` > `lu`. A load in EX never redirects.
- `stall_count` increments on every cycle where pc_write=0 or id_ex_bubble=1. It saturates at all-ones and never wraps.
- Rs1 = x0 or Rs2 = x0 never matches, because RD≠0 is required.

## Timing
- Outputs are combinational from the state, counter and inputs. They are valid before the negedge that captures the pipeline registers.
- Load-use: exactly 1 stall cycle, then the dependent instruction proceeds. Forwarding is handled elsewhere.
- Redirect: FLUSH_CYCLES bubble cycles in total, counting the detection cycle.
- Reset values, applied asynchronously on reset=0:
  - Internal state: state=RUN, counter=0, stall_count=0.
  - Outputs then take the RUN values for the current inputs. With all-zero input control bits: pc_write=1, if_id_write=1, id_ex_enable=1, bubble=0, flush=0, redirect=0.
- Reset asserted mid-FLUSH or mid-LOAD_STALL aborts immediately to RUN. Pending bubbles are dropped.

## Structure
- Shared package (`riscv_pipe_pkg`):
  - ID/EX field bit-position constants (LSB/MSB per field).
  - ID/EX total width 158.
  - FSM state encoding.
- One sub-module, `id_ex_unpack`: purely combinational slicing of the bus into named fields. It is reusable by the EX stage.

## Test plan
- Reset: reset=0 with `DataIn_ID_EX`=0, then reset=1 → pc_write=1, if_id_write=1, id_ex_enable=1, bubble=0, flush=0, redirect=0, stall_count=0.
- Load-use: MemRead=1, RD=5, if_id_rs1=5 → one cycle with pc_write=0, if_id_write=0, bubble=1; next cycle normal; stall_count=1.
- RD=0 guard: MemRead=1, RD=0, if_id_rs1=0 → no stall. Same with RD=7, if_id_rs2=7, if_id_uses_rs2=0 → no stall.
- Taken branch: Branch=1, branch_taken=1, FLUSH_CYCLES=2 → redirect=1 for 1 cycle; flush=1 and bubble=1 for 2 cycles; then RUN.
- Priority: simultaneous Jal=1 and an `lu` match → redirect path only; pc_write stays 1.
- Async reset during FLUSH (FLUSH_CYCLES=4, reset on cycle 2) → state RUN immediately; stall_count=0. Also, forced saturation with STALL_CNT_W=4: 20 stall cycles → stall_count=15.
